// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath blocks (address generator,
// MAC, line buffer): FSM state encoding, output-dimension helper, parameter
// legality check and counter-width helper.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of window positions along one axis in "valid" mode; any
    // remainder pixels that do not fit a full stride are dropped.
    function automatic int out_dim(input int img, input int k, input int stride);
        return (img - k) / stride + 1;
    endfunction

    // Width needed to count 0..max_val, never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic bit params_ok(input int img_w, input int img_h, input int k,
                                     input int stride, input int addr_w);
        longint pix;
        pix = longint'(img_w) * longint'(img_h);
        return (k >= 1) && (k <= 15) && (stride >= 1) && (stride <= k) &&
               (img_w >= k) && (img_h >= k) && (addr_w >= 1) && (addr_w <= 60) &&
               ((pix - 64'd1) < (64'd1 << addr_w));
    endfunction

endpackage

// File: rtl/conv_addr_gen_win_counter.sv
// win_counter: wrap counter 0..MAX_VAL used for each loop level of the window walk.
// Latency: count updates on the clock after en_i; wrap_o is combinational (en_i at max).
// Backpressure: none of its own; the caller gates en_i with the handshake.
// Ports: clk/rst (sync, active-high), clr_i forces zero, en_i advances,
//        cnt_o current count, wrap_o pulses with the enable that rolls max -> 0.
module win_counter import conv_pkg::*; #(
    parameter int MAX_VAL = 2,
    parameter int CW      = cnt_w(MAX_VAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_VAL);

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_o  = cnt_q;
    assign wrap_o = en_i && (cnt_q == MAX_C);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == MAX_C) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: walks every output pixel and kernel tap, emitting image/kernel/output addresses.
// Latency: first tuple valid the cycle after start; one tuple per cycle while ready is high.
// Backpressure: tuple advances only on valid&ready; ready low freezes every output.
// Ports: clk, rst (sync active-high), start pulse, ready in; valid, imAddr, kAddr,
//        filtAddr, firstTap, lastTap, busy, done out.
// Optional feature macro CONV_PAD_EN: "same" zero padding, stride forced to 1,
//        adds output pad (tap lies outside the image; imAddr then reads 0).
module conv_addr_gen import conv_pkg::*; #(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int KER_SIZE = 3,
    parameter int STRIDE   = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] imAddr,
    output logic [ADDR_W-1:0] kAddr,
    output logic [ADDR_W-1:0] filtAddr,
    output logic              firstTap,
    output logic              lastTap,
    output logic              busy,
`ifdef CONV_PAD_EN
    output logic              pad,
`endif
    output logic              done
);

`ifdef CONV_PAD_EN
    localparam int PAD   = (KER_SIZE - 1) / 2;
    localparam int STEP  = 1;
    localparam int OUT_W = IMG_W;
    localparam int OUT_H = IMG_H;
`else
    localparam int PAD   = 0;
    localparam int STEP  = STRIDE;
    localparam int OUT_W = out_dim(IMG_W, KER_SIZE, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, KER_SIZE, STRIDE);
`endif

    if (!params_ok(IMG_W, IMG_H, KER_SIZE, STRIDE, ADDR_W)) begin : g_bad_params
        $error("conv_addr_gen: illegal IMG_W/IMG_H/KER_SIZE/STRIDE/ADDR_W combination");
    end

    // Running bases are signed and two bits wider than the address so that
    // negative padding offsets and the overhang past the last row stay exact.
    localparam int SW = ADDR_W + 2;
    localparam int KW = cnt_w(KER_SIZE - 1);
    localparam int CW = cnt_w(OUT_W - 1);
    localparam int RW = cnt_w(OUT_H - 1);

    localparam logic signed [SW-1:0] ROW_INIT = SW'(-PAD * IMG_W);
    localparam logic signed [SW-1:0] COL_INIT = SW'(-PAD);
    localparam logic signed [SW-1:0] ROW_STEP = SW'(STEP * IMG_W);
    localparam logic signed [SW-1:0] COL_STEP = SW'(STEP);
    // Moving from tap (kr, K-1) to (kr+1, 0): down one image row, back K-1 columns.
    localparam logic signed [SW-1:0] TAP_ROW  = SW'(IMG_W - (KER_SIZE - 1));
    localparam logic [KW-1:0]        KMAX     = KW'(KER_SIZE - 1);

    state_e state_q, state_d;
    logic   run, adv, clr;
    logic   kc_wrap, kr_wrap, c_wrap, r_wrap;
    logic [KW-1:0] kc, kr;
    logic [CW-1:0] c_cnt;
    logic [RW-1:0] r_cnt;

    logic signed [SW-1:0] row_base_q, row_base_d;   // (r*STEP - PAD) * IMG_W
    logic signed [SW-1:0] col_pos_q,  col_pos_d;    //  c*STEP - PAD
    logic signed [SW-1:0] tap_off_q,  tap_off_d;    //  kr*IMG_W + kc
    logic [ADDR_W-1:0]    kaddr_q,    kaddr_d;
    logic [ADDR_W-1:0]    filt_q,     filt_d;

    assign run = (state_q == RUN);
    assign adv = run && ready;
    assign clr = !run;

    win_counter #(.MAX_VAL(KER_SIZE - 1), .CW(KW)) u_kc (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(adv),     .cnt_o(kc),    .wrap_o(kc_wrap));
    win_counter #(.MAX_VAL(KER_SIZE - 1), .CW(KW)) u_kr (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(kc_wrap), .cnt_o(kr),    .wrap_o(kr_wrap));
    win_counter #(.MAX_VAL(OUT_W - 1),    .CW(CW)) u_c (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(kr_wrap), .cnt_o(c_cnt), .wrap_o(c_wrap));
    win_counter #(.MAX_VAL(OUT_H - 1),    .CW(RW)) u_r (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(c_wrap),  .cnt_o(r_cnt), .wrap_o(r_wrap));

    // Pixel position is carried by the running bases; the c/r counts only
    // feed the wrap chain.
    logic unused_pos;
    assign unused_pos = ^{c_cnt, r_cnt};

`ifdef CONV_PAD_EN
    logic signed [SW-1:0] row_pos_q, row_pos_d;     //  r - PAD
    logic signed [SW-1:0] tap_x, tap_y;
    logic                 outside;

    assign tap_x   = col_pos_q + $signed({{(SW-KW){1'b0}}, kc});
    assign tap_y   = row_pos_q + $signed({{(SW-KW){1'b0}}, kr});
    assign outside = (tap_x < 0) || (tap_x >= SW'(IMG_W)) ||
                     (tap_y < 0) || (tap_y >= SW'(IMG_H));
    assign pad     = run && outside;

    always_comb begin
        row_pos_d = row_pos_q;
        if (clr || (adv && r_wrap)) begin
            row_pos_d = COL_INIT;
        end else if (adv && c_wrap) begin
            row_pos_d = row_pos_q + COL_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) row_pos_q <= COL_INIT;
        else     row_pos_q <= row_pos_d;
    end
`endif

    // FSM next state and outputs.
    always_comb begin
        state_d  = state_q;
        valid    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        firstTap = 1'b0;
        lastTap  = 1'b0;
        imAddr   = '0;
        kAddr    = '0;
        filtAddr = '0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                valid    = 1'b1;
                busy     = 1'b1;
                firstTap = (kc == '0) && (kr == '0);
                lastTap  = (kc == KMAX) && (kr == KMAX);
                imAddr   = ADDR_W'(row_base_q + col_pos_q + tap_off_q);
`ifdef CONV_PAD_EN
                if (outside) imAddr = '0;
`endif
                kAddr    = kaddr_q;
                filtAddr = filt_q;
                if (adv && r_wrap) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Running address bases; the wrap flags are already qualified by adv.
    always_comb begin
        row_base_d = row_base_q;
        col_pos_d  = col_pos_q;
        tap_off_d  = tap_off_q;
        kaddr_d    = kaddr_q;
        filt_d     = filt_q;
        if (clr) begin
            row_base_d = ROW_INIT;
            col_pos_d  = COL_INIT;
            tap_off_d  = '0;
            kaddr_d    = '0;
            filt_d     = '0;
        end else if (adv) begin
            if (kr_wrap)      tap_off_d = '0;
            else if (kc_wrap) tap_off_d = tap_off_q + TAP_ROW;
            else              tap_off_d = tap_off_q + 1'b1;
            kaddr_d = kr_wrap ? '0 : kaddr_q + 1'b1;
            if (c_wrap)       col_pos_d = COL_INIT;
            else if (kr_wrap) col_pos_d = col_pos_q + COL_STEP;
            if (r_wrap)       row_base_d = ROW_INIT;
            else if (c_wrap)  row_base_d = row_base_q + ROW_STEP;
            if (kr_wrap)      filt_d = filt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_base_q <= ROW_INIT;
            col_pos_q  <= COL_INIT;
            tap_off_q  <= '0;
            kaddr_q    <= '0;
            filt_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            col_pos_q  <= col_pos_d;
            tap_off_q  <= tap_off_d;
            kaddr_q    <= kaddr_d;
            filt_q     <= filt_d;
        end
    end

endmodule
